// File: rtl/btn_arb_pkg.sv
// Shared types, default constants and the round-robin search used by the
// button event arbiter.
package btn_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } arb_state_e;

    localparam int unsigned BTN_N_DEFAULT      = 4;
    localparam int unsigned LONG_TICKS_DEFAULT = 190;

    // Returns the first set request at or above ptr, wrapping modulo n.
    // Vectors are sized for the largest supported button count (8).
    function automatic logic [2:0] rr_find(input logic [7:0]  req,
                                           input logic [2:0]  ptr,
                                           input int unsigned n);
        logic [2:0]  idx;
        logic        found;
        int unsigned pos;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            pos = (32'(ptr) + k) % n;
            if (k < n && !found && req[3'(pos)]) begin
                idx   = 3'(pos);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Per-button hold counter: counts cycles while the debounced level is high,
// saturates at LONG_TICKS and emits a single registered pulse per hold.
module hold_timer #(
    parameter int unsigned LONG_TICKS = 190
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic long_o
);

    localparam int unsigned CNT_W = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0] TC     = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] TC_PRE = CNT_W'(LONG_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shot_q, shot_d;

    // Next count and one-shot: fires on the edge the count lands on TC.
    always_comb begin
        cnt_d  = '0;
        shot_d = 1'b0;
        if (level_i) begin
            cnt_d  = (cnt_q == TC) ? cnt_q : cnt_q + 1'b1;
            shot_d = (cnt_q == TC_PRE);
        end
    end

    // Counter and one-shot registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            shot_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            shot_q <= shot_d;
        end
    end

    assign long_o = shot_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Latches button press pulses as pending requests and serves them one at a
// time, round robin, over a valid/ready handshake.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
//
//   state      | meaning
//   ST_IDLE    | no event presented; grant next pending request if any
//   ST_PRESENT | evt_valid high, evt_id/evt_long held until evt_ready
module button_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int unsigned N_BTN      = BTN_N_DEFAULT,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned LONG_TICKS = LONG_TICKS_DEFAULT
) (
    input  logic             clkDiv190,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_id,
    output logic             evt_long,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);
    localparam logic [N_BTN-1:0] ONE_HOT0 = N_BTN'(1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] evt_id_q, evt_id_d;
    logic             evt_long_q, evt_long_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] long_pending_q, long_pending_d;
    logic             overflow_q, overflow_d;

    logic [N_BTN-1:0] req;
    logic [IDX_W-1:0] gnt;
    logic [N_BTN-1:0] gnt_mask;
    logic [N_BTN-1:0] pend_clr;
    logic [N_BTN-1:0] long_clr;
    logic [N_BTN-1:0] long_set;
    logic             ovf_hit;

`ifdef LONG_PRESS_EN
    for (genvar i = 0; i < N_BTN; i++) begin : g_hold
        hold_timer #(
            .LONG_TICKS(LONG_TICKS)
        ) u_hold (
            .clk_i  (clkDiv190),
            .rst_i  (rst),
            .level_i(btn_level[i]),
            .long_o (long_set[i])
        );
    end
`else
    localparam int unsigned unused_ticks = LONG_TICKS;
    logic unused_level;
    assign unused_level = ^btn_level;
    assign long_set     = '0;
`endif

    assign req      = pending_q | long_pending_q;
    assign gnt      = IDX_W'(rr_find(8'(req), 3'(ptr_q), N_BTN));
    assign gnt_mask = ONE_HOT0 << gnt;

    // Arbitration FSM, request bookkeeping and sticky overflow.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        evt_id_d   = evt_id_q;
        evt_long_d = evt_long_q;
        pend_clr   = '0;
        long_clr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_PRESENT;
                    evt_id_d = gnt;
                    if (|(long_pending_q & gnt_mask)) begin
                        evt_long_d = 1'b1;
                        long_clr   = gnt_mask;
                    end else begin
                        evt_long_d = 1'b0;
                        pend_clr   = gnt_mask;
                    end
                end
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (evt_id_q == LAST_IDX) ? '0 : evt_id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new pulse wins over the grant clearing the same bit.
        pending_d      = (pending_q & ~pend_clr) | btn_pulse;
        long_pending_d = (long_pending_q & ~long_clr) | long_set;
        ovf_hit        = (|(btn_pulse & pending_q & ~pend_clr))
                       | (|(long_set & long_pending_q & ~long_clr));
        overflow_d     = (overflow_q & ~clr_overflow) | ovf_hit;
    end

    // State and request registers.
    always_ff @(posedge clkDiv190 or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            evt_id_q       <= '0;
            evt_long_q     <= 1'b0;
            pending_q      <= '0;
            long_pending_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            evt_id_q       <= evt_id_d;
            evt_long_q     <= evt_long_d;
            pending_q      <= pending_d;
            long_pending_q <= long_pending_d;
            overflow_q     <= overflow_d;
        end
    end

    assign evt_valid = (state_q == ST_PRESENT);
    assign evt_id    = evt_id_q;
    assign evt_long  = evt_long_q;
    assign overflow  = overflow_q;
    assign busy      = (|pending_q) | (|long_pending_q) | (state_q == ST_PRESENT);

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

    localparam int N = 4;
`ifdef LONG_PRESS_EN
    localparam int LT = 8;
`else
    localparam int LT = 190;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_pulse;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_long;
    logic       overflow;
    logic       clr_overflow;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: set of pending buttons, presented event, pointer
    bit m_pend [N];
    bit m_pres;
    int m_cur;
    int m_ptr;
    bit m_ovf;

    button_event_arbiter #(
        .N_BTN(N), .IDX_W(2), .LONG_TICKS(LT)
    ) dut (
        .clkDiv190(clk), .rst(rst), .btn_pulse(btn_pulse), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_long(evt_long), .overflow(overflow), .clr_overflow(clr_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_pres = 1'b0;
        m_cur  = 0;
        m_ptr  = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the abstract behaviour.
    task automatic model_step(input logic [3:0] p, input logic r, input logic c);
        int g;
        bit hit;
        g   = -1;
        hit = 1'b0;
        if (!m_pres) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_pres    = 1'b1;
                m_cur     = g;
            end
        end else if (r) begin
            m_pres = 1'b0;
            m_ptr  = (m_cur + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                if (m_pend[i]) hit = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        m_ovf = (m_ovf && !c) || hit;
    endtask

    function automatic bit model_busy();
        bit b;
        b = m_pres;
        for (int i = 0; i < N; i++) b |= m_pend[i];
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, evt_valid, m_pres);
        if (m_pres) check({tag, ".id"}, evt_id, m_cur);
        check({tag, ".long"}, evt_long, 0);
        check({tag, ".ovf"}, overflow, m_ovf);
        check({tag, ".busy"}, busy, model_busy());
    endtask

    task automatic cycle(input string tag, input logic [3:0] p, input logic r, input logic c);
        btn_pulse    = p;
        evt_ready    = r;
        clr_overflow = c;
        @(posedge clk);
        model_step(p, r, c);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        btn_pulse    = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        btn_level    = '0;
        rst          = 1'b1;
        #2;
        model_reset();
        check({tag, ".rst_valid"}, evt_valid, 0);
        check({tag, ".rst_id"}, evt_id, 0);
        check({tag, ".rst_long"}, evt_long, 0);
        check({tag, ".rst_ovf"}, overflow, 0);
        check({tag, ".rst_busy"}, busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ids [$];
        int when [$];
        int n_ev;
        int first_t;

        rst = 1'b1;
        do_reset("init");

        // single press on button 2
        cycle("single.e1", 4'b0100, 1, 0);
        check("single.lat1", evt_valid, 0);
        cycle("single.e2", 4'b0000, 1, 0);
        check("single.valid", evt_valid, 1);
        check("single.id", evt_id, 2);
        cycle("single.e3", 4'b0000, 1, 0);
        check("single.drop", evt_valid, 0);
        check("single.idle", busy, 0);

        // three presses at once, served 0,1,3 two cycles apart
        do_reset("multi");
        cycle("multi.e1", 4'b1011, 1, 0);
        for (int t = 2; t <= 8; t++) begin
            cycle($sformatf("multi.e%0d", t), 4'b0000, 1, 0);
            if (evt_valid) begin
                ids.push_back(int'(evt_id));
                when.push_back(t);
            end
        end
        check("multi.count", ids.size(), 3);
        if (ids.size() == 3) begin
            check("multi.id0", ids[0], 0);
            check("multi.id1", ids[1], 1);
            check("multi.id2", ids[2], 3);
            check("multi.t0", when[0], 2);
            check("multi.t1", when[1], 4);
            check("multi.t2", when[2], 6);
        end
        check("multi.ovf", overflow, 0);

        // fairness: after serving 1, id 2 goes before id 0
        do_reset("rr");
        cycle("rr.e1", 4'b0010, 1, 0);
        cycle("rr.e2", 4'b0000, 1, 0);
        check("rr.first", evt_id, 1);
        cycle("rr.e3", 4'b0000, 1, 0);
        cycle("rr.e4", 4'b0101, 1, 0);
        cycle("rr.e5", 4'b0000, 1, 0);
        check("rr.second", evt_id, 2);
        cycle("rr.e6", 4'b0000, 1, 0);
        cycle("rr.e7", 4'b0000, 1, 0);
        check("rr.third", evt_id, 0);
        cycle("rr.e8", 4'b0000, 1, 0);

        // backpressure, overflow from a repeated press, clear
        do_reset("bp");
        cycle("bp.e1", 4'b0001, 0, 0);
        cycle("bp.e2", 4'b0000, 0, 0);
        cycle("bp.e3", 4'b1000, 0, 0);
        check("bp.no_ovf", overflow, 0);
        cycle("bp.e4", 4'b1000, 0, 0);
        check("bp.ovf", overflow, 1);
        for (int t = 0; t < 10; t++) begin
            cycle($sformatf("bp.hold%0d", t), 4'b0000, 0, 0);
            check("bp.stable_id", evt_id, 0);
            check("bp.stable_v", evt_valid, 1);
        end
        cycle("bp.clr", 4'b0000, 0, 1);
        check("bp.cleared", overflow, 0);
        for (int t = 0; t < 4; t++) cycle("bp.drain", 4'b0000, 1, 0);

        // reset while presenting with further requests pending
        do_reset("rp");
        cycle("rp.e1", 4'b0001, 0, 0);
        cycle("rp.e2", 4'b0000, 0, 0);
        cycle("rp.e3", 4'b0110, 0, 0);
        #3;
        do_reset("rp.mid");
        for (int t = 0; t < 5; t++) begin
            cycle("rp.quiet", 4'b0000, 1, 0);
            check("rp.no_evt", evt_valid, 0);
        end

        // randomized traffic against the model
        do_reset("rnd");
        for (int t = 0; t < 800; t++) begin
            logic [3:0] p;
            logic       r;
            logic       c;
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) == 0);
            cycle("rnd", p, r, c);
        end

`ifdef LONG_PRESS_EN
        // hold button 1 for 20 cycles: one long event, 2 edges after count hits 8
        do_reset("long");
        btn_level = 4'b0010;
        evt_ready = 1'b1;
        n_ev      = 0;
        first_t   = -1;
        for (int t = 1; t <= 24; t++) begin
            if (t == 21) btn_level = 4'b0000;
            @(posedge clk);
            #1;
            if (evt_valid) begin
                n_ev++;
                if (first_t < 0) first_t = t;
                check("long.id", evt_id, 1);
                check("long.flag", evt_long, 1);
            end
        end
        check("long.count", n_ev, 1);
        check("long.time", first_t, 10);
        check("long.idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects one-cycle press pulses from N debouncer instances and latches each press as a pending request. Round-robin arbitration serves pending requests one at a time to a single downstream consumer over a valid/ready handshake. Sits between the per-button debouncers and the control FSM that acts on key presses, all on the divided 190 Hz clock. Optionally detects long presses from the debounced button levels.

## Interface
- N_BTN, 4, number of button inputs (2..8)
- IDX_W, 2, width of event index; must satisfy 2^IDX_W >= N_BTN
- LONG_TICKS, 190, hold length in clock cycles that qualifies as a long press (about 1 s at 190 Hz); only used with LONG_PRESS_EN

- clkDiv190  in  1  divided system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_pulse  in  N_BTN  one-cycle press pulses from debouncers
- btn_level  in  N_BTN  debounced button levels; ignored without LONG_PRESS_EN
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_id  out  IDX_W  index of the presented button
- evt_long  out  1  presented event is a long press
- overflow  out  1  sticky flag: a press was lost
- clr_overflow  in  1  synchronous clear of overflow
- busy  out  1  high when any request is pending or an event is being presented

## Operation
- pending[i] is set when btn_pulse[i] is sampled high.
- The FSM has two states:
  - IDLE: if any request is set, grant the first index at or above ptr, wrapping modulo N_BTN. On the same edge, load evt_id, clear that request bit and go to PRESENT. If no request is set, stay in IDLE.
  - PRESENT: evt_valid=1. evt_id and evt_long hold stable until a cycle in which evt_ready=1. On that edge: go to IDLE, set ptr to (granted index + 1) mod N_BTN, drop evt_valid.
- Maximum throughput is one event per two cycles.
- Simultaneous events:
  - Set wins over clear. If a pulse arrives on the index being granted in that same cycle, that pending bit stays set.
  - A pulse on an index whose pending bit is already set (and not being cleared that cycle) sets overflow. The press is dropped.
  - A pulse on the index currently being presented is a new request. It does not set overflow.
  - If clr_overflow and a new overflow condition occur in the same cycle, overflow ends up set.
- busy = |pending | |long_pending | (state==PRESENT).
- Reset values: evt_valid=0, evt_id=0, evt_long=0, overflow=0, busy=0, ptr=0, pending=0, state=IDLE. Reset mid-PRESENT drops the event and clears all requests.

## Timing
- A pulse sampled at edge t makes pending visible after t. The grant happens at edge t+1, and evt_valid is high after edge t+1, so latency is 2 edges.
- With evt_ready tied high, evt_valid is a one-cycle pulse and the next grant occurs at the following edge.
- evt_id and evt_long are registered and must not change while evt_valid=1 and evt_ready=0.
- overflow rises the edge after the offending pulse is sampled.
- clr_overflow takes effect at the next edge.

## Configuration
- Macro: LONG_PRESS_EN.
- Defined:
  - Each button has a hold counter. It increments while btn_level[i]=1, saturates at LONG_TICKS, and clears when btn_level[i]=0.
  - When the counter reaches LONG_TICKS, long_pending[i] is set, once per hold.
  - The request vector for arbitration is pending | long_pending.
  - When an index is granted with long_pending set, the block presents evt_long=1 and clears only long_pending. Otherwise it presents evt_long=0 and clears pending.
  - The short-press pulse is still reported separately.
  - Setting long_pending while it is already set raises overflow.
- Undefined:
  - No counters are built and btn_level is unused.
  - evt_long is constant 0.

## Structure
- Package btn_arb_pkg holds:
  - the state enum (ST_IDLE, ST_PRESENT)
  - the default constants for N_BTN and LONG_TICKS
  - a round-robin find-first function that takes the request vector and ptr and returns the index.
- Sub-module hold_timer: one counter, one saturating compare and a one-shot long-press output. Instantiated N_BTN times, only under LONG_PRESS_EN.

## Test plan
- Single press: pulse on btn_pulse[2] with evt_ready=1 -> evt_valid high 2 edges later for one cycle, evt_id=2, evt_long=0, busy returns to 0.
- Multiple presses from reset: btn_pulse=4'b1011 in one cycle with ready=1 -> events with ids 0, 1, 3 in order, spaced 2 cycles apart, overflow=0.
- Round-robin fairness: serve id 1 (ptr becomes 2), then pulse 4'b0101 -> id 2 is served before id 0.
- Backpressure and overflow: hold ready=0 for 10 cycles -> evt_id stays stable. Pulse btn 3 twice while its pending bit is set -> overflow=1. Assert clr_overflow -> overflow=0 the next edge.
- Long press (LONG_PRESS_EN, LONG_TICKS=8): btn_level[1] high for 20 cycles -> exactly one event with id=1 and evt_long=1, issued 2 edges after the counter reaches 8.
- Reset during PRESENT with ready=0 and pending=4'b0110 -> after rst, evt_valid=0, busy=0, and no events until a new pulse arrives.
